// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared definitions for the regfile_sb register file.
//   * state_e : soft-clear engine states (ST_IDLE, ST_CLEAR)
//   * DATA_W / ADDR_W : default register width and index width
//   * REG_A0 / REG_A7 : ABI indices (a0, a7) for wiring the debug port
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam int REG_A0 = 10;
    localparam int REG_A7 = 17;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- one pending bit per register, used for hazard detection.
// Ports:
//   clk, rstn               clock, asynchronous active-low reset
//   wr_en_i / wr_idx_i      writeback retires the producer of wr_idx_i (bit cleared)
//   iss_en_i / iss_idx_i    an instruction issues with destination iss_idx_i (bit set)
//   sclr_en_i / sclr_idx_i  soft-clear engine zeroes one entry (bit cleared)
//   raddr1_i / raddr2_i     read-port indices
//   rbusy1_o / rbusy2_o     pending bit of each read-port index
// Priority per bit: soft clear > issue > writeback. Issue beats writeback
// because a same-cycle issue is a newer producer still in flight.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_idx_i,
    input  logic              iss_en_i,
    input  logic [ADDR_W-1:0] iss_idx_i,
    input  logic              sclr_en_i,
    input  logic [ADDR_W-1:0] sclr_idx_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic              rbusy1_o,
    output logic              rbusy2_o
);

    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] pend_d;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            if ((ZERO_REG != 0) && (gi == 0)) begin : g_zero
                // Hard-wired zero register can never have a producer in flight.
                assign pend_d[gi] = 1'b0;
            end else begin : g_bit
                assign pend_d[gi] =
                    (sclr_en_i && (sclr_idx_i == ADDR_W'(gi))) ? 1'b0 :
                    (iss_en_i  && (iss_idx_i  == ADDR_W'(gi))) ? 1'b1 :
                    (wr_en_i   && (wr_idx_i   == ADDR_W'(gi))) ? 1'b0 :
                    pend_q[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign rbusy1_o = pend_q[raddr1_i];
    assign rbusy2_o = pend_q[raddr2_i];

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- register file with 2 read ports, 1 write port, a debug read
// port, a pending-write scoreboard and a sequential soft-clear engine.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   raddr1/2, rdata1/2        combinational read ports
//   rbusy1/2                  pending write outstanding on raddr1/2
//   we, waddr, wdata          writeback port
//   iss_valid, iss_rd         issue marks iss_rd pending
//   clr_req, clr_busy         soft-clear request / clear in progress
//   dbg_addr, dbg_data        debug read port, never forwarded
// Build option: define REGFILE_BYPASS_EN to forward the writeback data and a
// cleared busy flag onto matching read ports in the same cycle.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NUM_REGS = 2**ADDR_W;
    localparam bit ZR       = (ZERO_REG != 0);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_active;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic wr_ok;
    logic iss_ok;
    logic sb_busy1;
    logic sb_busy2;

    // Writes and issues are accepted only while idle and never to a hard zero.
    assign wr_ok  = we && (state_q == ST_IDLE) && !(ZR && (waddr == '0));
    assign iss_ok = iss_valid && (state_q == ST_IDLE) && !(ZR && (iss_rd == '0));

    // ---------------- soft-clear FSM: state register ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- soft-clear FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                // cnt wraps to 0 naturally on the last entry.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(NUM_REGS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- soft-clear FSM: outputs ----------------
    always_comb begin
        clr_active = (state_q == ST_CLEAR);
        clr_busy   = clr_active;
    end

    // ---------------- register array ----------------
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (clr_active) begin
            regs_d[cnt_q] = '0;
        end else if (wr_ok) begin
            regs_d[waddr] = wdata;
        end
        if (ZR) begin
            regs_d[0] = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // ---------------- scoreboard ----------------
    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rstn       (rstn),
        .wr_en_i    (wr_ok),
        .wr_idx_i   (waddr),
        .iss_en_i   (iss_ok),
        .iss_idx_i  (iss_rd),
        .sclr_en_i  (clr_active),
        .sclr_idx_i (cnt_q),
        .raddr1_i   (raddr1),
        .raddr2_i   (raddr2),
        .rbusy1_o   (sb_busy1),
        .rbusy2_o   (sb_busy2)
    );

    // ---------------- read ports ----------------
`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rdata1 = regs_q[raddr1];
        rbusy1 = sb_busy1;
        rdata2 = regs_q[raddr2];
        rbusy2 = sb_busy2;
        // Forward the retiring value; a same-cycle issue shows up next cycle.
        if (wr_ok && (waddr == raddr1)) begin
            rdata1 = wdata;
            rbusy1 = 1'b0;
        end
        if (wr_ok && (waddr == raddr2)) begin
            rdata2 = wdata;
            rbusy2 = 1'b0;
        end
    end
`else
    always_comb begin
        rdata1 = regs_q[raddr1];
        rbusy1 = sb_busy1;
        rdata2 = regs_q[raddr2];
        rbusy2 = sb_busy2;
    end
`endif

    // Entry 0 is held at zero in the array when ZR, so no extra read masking.
    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic [4:0]  raddr1, raddr2, waddr, iss_rd, dbg_addr;
    logic [31:0] rdata1, rdata2, wdata, dbg_data;
    logic        rbusy1, rbusy2, we, iss_valid, clr_req, clr_busy;

    int tests = 0;
    int fails = 0;
    int n;

    regfile_sb dut (
        .clk       (clk),
        .rstn      (rstn),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .rbusy1    (rbusy1),
        .rbusy2    (rbusy2),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[TB] %s obs=%h exp=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; we = 1'b0; iss_valid = 1'b0; clr_req = 1'b0;
        raddr1 = 5'd5; raddr2 = 5'd0; waddr = '0; wdata = '0; iss_rd = '0;
        dbg_addr = '0;
        #12;
        // reset state
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_rdata2", rdata2, 32'h0);
        chk("rst_rbusy1", {31'b0, rbusy1}, 32'h0);
        chk("rst_rbusy2", {31'b0, rbusy2}, 32'h0);
        chk("rst_clr_busy", {31'b0, clr_busy}, 32'h0);
        rstn = 1'b1;
        tick();

        // write and read index 10 (a0)
        we = 1'b1; waddr = 5'd10; wdata = 32'hDEADBEEF; raddr1 = 5'd10; dbg_addr = 5'(REG_A0);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("wr10_same_cycle", rdata1, 32'hDEADBEEF);
`else
        chk("wr10_same_cycle", rdata1, 32'h0);
`endif
        chk("dbg_no_bypass", dbg_data, 32'h0);
        tick();
        we = 1'b0;
        chk("wr10_rdata1", rdata1, 32'hDEADBEEF);
        chk("wr10_dbg", dbg_data, 32'hDEADBEEF);

        // write to hard zero register
        raddr2 = 5'd0;
        wr(5'd0, 32'h1234);
        chk("wr0_rdata2", rdata2, 32'h0);

        // scoreboard: issue, retire, same-cycle issue+write
        raddr1 = 5'd7;
        iss_valid = 1'b1; iss_rd = 5'd7;
        #1;
        chk("iss7_same_cycle", {31'b0, rbusy1}, 32'h0);
        tick();
        iss_valid = 1'b0;
        chk("iss7_busy", {31'b0, rbusy1}, 32'h1);
        we = 1'b1; waddr = 5'd7; wdata = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("wr7_busy_same", {31'b0, rbusy1}, 32'h0);
`else
        chk("wr7_busy_same", {31'b0, rbusy1}, 32'h1);
`endif
        tick();
        we = 1'b0;
        chk("wr7_busy", {31'b0, rbusy1}, 32'h0);
        chk("wr7_data", rdata1, 32'h77);
        we = 1'b1; waddr = 5'd7; wdata = 32'h78; iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        we = 1'b0; iss_valid = 1'b0;
        chk("wriss7_busy", {31'b0, rbusy1}, 32'h1);
        chk("wriss7_data", rdata1, 32'h78);
        iss_valid = 1'b1; iss_rd = 5'd0; raddr2 = 5'd0;
        tick();
        iss_valid = 1'b0;
        chk("iss0_busy", {31'b0, rbusy2}, 32'h0);

        // preload and soft clear
        wr(5'd1, 32'h11111111);
        wr(5'd17, 32'h17171717);
        wr(5'd31, 32'h31313131);
        dbg_addr = 5'(REG_A7);
        #1;
        chk("pre_dbg17", dbg_data, 32'h17171717);
        clr_req = 1'b1;
        #1;
        chk("clr_busy_pre", {31'b0, clr_busy}, 32'h0);
        tick();
        clr_req = 1'b0;
        chk("clr_busy_start", {31'b0, clr_busy}, 32'h1);
        n = 0;
        while (clr_busy && n < 100) begin
            if (n == 10) begin
                we = 1'b1; waddr = 5'd2; wdata = 32'hBAD0BAD0;
                iss_valid = 1'b1; iss_rd = 5'd3;
            end else begin
                we = 1'b0; iss_valid = 1'b0;
            end
            tick();
            n++;
        end
        we = 1'b0; iss_valid = 1'b0;
        chk("clr_cycles", n, 32'd32);
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i); raddr2 = 5'(i);
            #1;
            chk($sformatf("clr_data_%0d", i), rdata1, 32'h0);
            chk($sformatf("clr_busy_%0d", i), {31'b0, rbusy2}, 32'h0);
        end

        // reset in the middle of a clear
        wr(5'd5, 32'hAA);
        iss_valid = 1'b1; iss_rd = 5'd9;
        tick();
        iss_valid = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rstn = 1'b0;
        #1;
        chk("midrst_clr_busy", {31'b0, clr_busy}, 32'h0);
        #3;
        rstn = 1'b1;
        tick();
        raddr1 = 5'd5; raddr2 = 5'd9;
        #1;
        chk("midrst_clr_busy2", {31'b0, clr_busy}, 32'h0);
        chk("midrst_r5", rdata1, 32'h0);
        chk("midrst_busy9", {31'b0, rbusy2}, 32'h0);
        raddr1 = 5'd4;
        wr(5'd4, 32'h44);
        chk("midrst_idle_wr", rdata1, 32'h44);

        // write-to-read forwarding
        raddr1 = 5'd3;
        we = 1'b1; waddr = 5'd3; wdata = 32'h55;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same_cycle", rdata1, 32'h55);
`else
        chk("byp_same_cycle", rdata1, 32'h0);
`endif
        tick();
        we = 1'b0;
        chk("byp_next_cycle", rdata1, 32'h55);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the pipelined core.
- Two combinational read ports, one write port, and one debug read port. The debug port replaces the fixed a0/a7 taps.
- Adds a per-register pending-write scoreboard for hazard detection.
- Adds a sequential soft-clear engine that zeroes the file one entry per cycle without asserting reset.
- Sits between decode (read, issue) and writeback (write).

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W, derived, not overridable.
- ZERO_REG, 1, 1 = index 0 reads 0, is never written and is never pending; 0 = index 0 is an ordinary register.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rstn  in  1  asynchronous active-low reset.
- raddr1  in  ADDR_W  read port 1 index.
- raddr2  in  ADDR_W  read port 2 index.
- rdata1  out  DATA_W  read port 1 data.
- rdata2  out  DATA_W  read port 2 data.
- rbusy1  out  1  pending write outstanding on raddr1.
- rbusy2  out  1  pending write outstanding on raddr2.
- we  in  1  writeback write enable.
- waddr  in  ADDR_W  writeback index.
- wdata  in  DATA_W  writeback data.
- iss_valid  in  1  an instruction with destination iss_rd issues this cycle.
- iss_rd  in  ADDR_W  destination index of the issuing instruction.
- clr_req  in  1  soft-clear request, single-cycle pulse or level.
- clr_busy  out  1  soft clear in progress.
- dbg_addr  in  ADDR_W  debug read index.
- dbg_data  out  DATA_W  debug read data, combinational, never bypassed.

Behaviour:
- Clock and reset: one clock, clk. rstn is asynchronous and active-low. While rstn is low:
  - all registers = 0, all pending bits = 0;
  - FSM = IDLE, clear counter = 0, clr_busy = 0.
- Reset asserted mid-clear aborts the clear immediately; the result is the same as a full reset.
- Reads: combinational array lookup.
  - Index 0 returns 0 when ZERO_REG = 1.
  - rbusyN = pending[raddrN]; it is 0 for index 0 when ZERO_REG = 1.
- Write: at posedge when we = 1, FSM = IDLE, and not (ZERO_REG and waddr == 0):
  - registers[waddr] <= wdata;
  - pending[waddr] <= 0.
  - Latency: new data is visible on the read ports the cycle after the edge (without bypass).
- Issue: at posedge when iss_valid = 1, FSM = IDLE, and not (ZERO_REG and iss_rd == 0): pending[iss_rd] <= 1.
- Simultaneous write and issue to the same index in one cycle: register data is written, and the pending bit ends at 1 (issue wins; a newer producer is in flight).
- FSM states:
  - IDLE: on clr_req = 1, go to CLEAR with cnt = 0, and clr_busy = 1 from the next cycle.
  - CLEAR: each cycle, registers[cnt] <= 0, pending[cnt] <= 0, cnt <= cnt + 1. When cnt == NUM_REGS-1, return to IDLE and set clr_busy = 0.
  - A clear takes exactly NUM_REGS cycles in CLEAR.
- During CLEAR:
  - we and iss_valid are ignored; data is dropped and writeback must stall on clr_busy;
  - clr_req is ignored;
  - reads return the partially cleared contents.
- clr_req held high on the cycle the FSM returns to IDLE starts a new clear on the next edge.
- cnt is ADDR_W bits and wraps naturally at NUM_REGS-1 → 0.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: when we = 1, FSM = IDLE, waddr == raddrN, and the index is writable:
  - rdataN = wdata and rbusyN = 0 in the same cycle (write-to-read forwarding);
  - if iss_valid to the same index also occurs in that cycle, rbusyN still shows 0 that cycle and 1 the next.
- Undefined: reads return the stored value until the edge; no forwarding logic is present.
- dbg_data is never bypassed in either case.

Decomposition:
- Shared package regfile_pkg holds:
  - the FSM state enum (ST_IDLE, ST_CLEAR);
  - the default widths DATA_W = 32 and ADDR_W = 5;
  - the ABI index constants REG_A0 = 10 and REG_A7 = 17, for top-level debug wiring.
- One sub-module: regfile_scoreboard. It holds the pending bit vector with the set/clear/clear-all priority rules and the two rbusy lookups.

Test Plan:
- Reset then read: raddr1 = 5, raddr2 = 0 → rdata1 = 0, rdata2 = 0, rbusy1/2 = 0, clr_busy = 0.
- Write and read: we = 1, waddr = 10, wdata = 0xDEADBEEF → next cycle rdata1 (raddr1 = 10) = 0xDEADBEEF and dbg_data (dbg_addr = 10) = 0xDEADBEEF. Write to index 0 with 0x1234 → rdata of index 0 stays 0.
- Scoreboard:
  - iss_valid, iss_rd = 7 → rbusy1 (raddr1 = 7) = 1 from the next cycle;
  - we, waddr = 7 → rbusy1 = 0 next cycle;
  - same-cycle we and iss to index 7 → rbusy1 = 1.
- Soft clear:
  - preload indices 1, 17 and 31 with non-zero values; pulse clr_req → clr_busy high for 32 cycles, then all reads 0 and all rbusy 0;
  - we asserted mid-clear is dropped.
- Reset mid-clear: assert rstn low at clear cycle 10 → clr_busy = 0 immediately; after release, all registers 0 and FSM idle.
- Bypass (REGFILE_BYPASS_EN defined): we, waddr = 3, wdata = 0x55, raddr1 = 3 → rdata1 = 0x55 in the same cycle. Without the macro → rdata1 shows the old value and updates next cycle.
